// File: rtl/box_move_ctrl.sv
// Keyboard/button driven box mover: decodes PS/2 WASD scan codes into held-key
// flags and steps a wrapping box center once every FRAMES_PER_STEP frame strobes.
module box_move_ctrl #(
  parameter int PIX_WIDTH       = 640,
  parameter int PIX_HEIGHT      = 480,
  parameter int PIX_STEP        = 3,
  parameter int BOX_HALF        = 90,
  parameter int FRAMES_PER_STEP = 1
) (
  input  logic       in_clock,
  input  logic       in_reset,
  input  logic       in_frame_stb,
  input  logic [7:0] in_kbd_code,
  input  logic       in_kbd_valid,
  input  logic       in_btn_up,
  input  logic       in_btn_down,
  input  logic       in_btn_left,
  input  logic       in_btn_right,
  output logic [9:0] out_x_left,
  output logic [9:0] out_x_right,
  output logic [8:0] out_y_top,
  output logic [8:0] out_y_bottom,
  output logic       out_move,
  output logic [1:0] out_dir
);

  localparam logic [10:0] XW       = 11'(PIX_WIDTH);
  localparam logic [10:0] XS       = 11'(PIX_STEP);
  localparam logic [10:0] XH       = 11'(BOX_HALF);
  localparam logic [9:0]  YW       = 10'(PIX_HEIGHT);
  localparam logic [9:0]  YS       = 10'(PIX_STEP);
  localparam logic [9:0]  YH       = 10'(BOX_HALF);
  localparam logic [9:0]  CX0      = 10'(PIX_WIDTH / 2);
  localparam logic [8:0]  CY0      = 9'(PIX_HEIGHT / 2);
  localparam logic [3:0]  DIV_LAST = 4'(FRAMES_PER_STEP - 1);

  localparam logic [7:0] KEY_W      = 8'h1D;
  localparam logic [7:0] KEY_A      = 8'h1C;
  localparam logic [7:0] KEY_S      = 8'h1B;
  localparam logic [7:0] KEY_D      = 8'h23;
  localparam logic [7:0] CODE_BREAK = 8'hF0;
  localparam logic [7:0] CODE_EXT   = 8'hE0;

  typedef enum logic [1:0] {ST_IDLE, ST_BREAK, ST_EXT, ST_EXT_BREAK} kbd_state_t;
  typedef enum logic [1:0] {DIR_UP = 2'd0, DIR_LEFT = 2'd1, DIR_DOWN = 2'd2, DIR_RIGHT = 2'd3} dir_t;

  kbd_state_t r_state;
  logic       r_key_w, r_key_a, r_key_s, r_key_d;
  logic [3:0] r_div;
  logic [9:0] r_cx;
  logic [8:0] r_cy;
  logic       r_move;
  dir_t       r_dir;

  logic        w_btn_any;
  logic        w_go_up, w_go_left, w_go_down, w_go_right;
  logic        w_dir_valid;
  dir_t        w_dir;
  logic [10:0] w_cx_ext;
  logic [9:0]  w_cy_ext;
  logic [9:0]  w_cx_next;
  logic [8:0]  w_cy_next;

  // Any pressed button takes the whole step away from the keyboard.
  assign w_btn_any  = in_btn_up | in_btn_down | in_btn_left | in_btn_right;
  assign w_go_up    = w_btn_any ? in_btn_up    : r_key_w;
  assign w_go_left  = w_btn_any ? in_btn_left  : r_key_a;
  assign w_go_down  = w_btn_any ? in_btn_down  : r_key_s;
  assign w_go_right = w_btn_any ? in_btn_right : r_key_d;

  assign w_cx_ext = {1'b0, r_cx};
  assign w_cy_ext = {1'b0, r_cy};

  // NOTE: every variable assigned in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    w_dir_valid = 1'b1;
    w_dir       = DIR_UP;
    if (w_go_up)         w_dir = DIR_UP;
    else if (w_go_left)  w_dir = DIR_LEFT;
    else if (w_go_down)  w_dir = DIR_DOWN;
    else if (w_go_right) w_dir = DIR_RIGHT;
    else                 w_dir_valid = 1'b0;
  end

  always_comb begin
    w_cx_next = r_cx;
    w_cy_next = r_cy;
    case (w_dir)
      DIR_UP:    w_cy_next = (w_cy_ext < YS) ? 9'(w_cy_ext + YW - YS) : 9'(w_cy_ext - YS);
      DIR_DOWN:  w_cy_next = (w_cy_ext + YS >= YW) ? 9'(w_cy_ext + YS - YW) : 9'(w_cy_ext + YS);
      DIR_LEFT:  w_cx_next = (w_cx_ext < XS) ? 10'(w_cx_ext + XW - XS) : 10'(w_cx_ext - XS);
      DIR_RIGHT: w_cx_next = (w_cx_ext + XS >= XW) ? 10'(w_cx_ext + XS - XW) : 10'(w_cx_ext + XS);
      default:   ;
    endcase
  end

  assign out_x_left   = (w_cx_ext >= XH) ? 10'(w_cx_ext - XH) : 10'(w_cx_ext + XW - XH);
  assign out_x_right  = (w_cx_ext + XH >= XW) ? 10'(w_cx_ext + XH - XW) : 10'(w_cx_ext + XH);
  assign out_y_top    = (w_cy_ext >= YH) ? 9'(w_cy_ext - YH) : 9'(w_cy_ext + YW - YH);
  assign out_y_bottom = (w_cy_ext + YH >= YW) ? 9'(w_cy_ext + YH - YW) : 9'(w_cy_ext + YH);
  assign out_move     = r_move;
  assign out_dir      = r_dir;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge in_clock or negedge in_reset) begin
    if (!in_reset) begin
      r_state <= ST_IDLE;
      r_key_w <= 1'b0;
      r_key_a <= 1'b0;
      r_key_s <= 1'b0;
      r_key_d <= 1'b0;
      r_div   <= '0;
      r_cx    <= CX0;
      r_cy    <= CY0;
      r_move  <= 1'b0;
      r_dir   <= DIR_UP;
    end else begin
      r_move <= 1'b0;

      if (in_kbd_valid) begin
        case (r_state)
          ST_IDLE: begin
            if (in_kbd_code == CODE_BREAK)    r_state <= ST_BREAK;
            else if (in_kbd_code == CODE_EXT) r_state <= ST_EXT;
            else begin
              if (in_kbd_code == KEY_W) r_key_w <= 1'b1;
              if (in_kbd_code == KEY_A) r_key_a <= 1'b1;
              if (in_kbd_code == KEY_S) r_key_s <= 1'b1;
              if (in_kbd_code == KEY_D) r_key_d <= 1'b1;
            end
          end
          ST_BREAK: begin
            if (in_kbd_code == KEY_W) r_key_w <= 1'b0;
            if (in_kbd_code == KEY_A) r_key_a <= 1'b0;
            if (in_kbd_code == KEY_S) r_key_s <= 1'b0;
            if (in_kbd_code == KEY_D) r_key_d <= 1'b0;
            r_state <= ST_IDLE;
          end
          ST_EXT:  r_state <= (in_kbd_code == CODE_BREAK) ? ST_EXT_BREAK : ST_IDLE;
          default: r_state <= ST_IDLE;
        endcase
      end

      // Flags are read as registered, so a byte arriving with the strobe only affects later steps.
      if (in_frame_stb) begin
        if (r_div == DIV_LAST) begin
          r_div <= '0;
          if (w_dir_valid) begin
            r_cx   <= w_cx_next;
            r_cy   <= w_cy_next;
            r_move <= 1'b1;
            r_dir  <= w_dir;
          end
        end else begin
          r_div <= r_div + 4'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_box_move_ctrl.sv
// Directed bench for box_move_ctrl: a default-parameter instance plus a
// FRAMES_PER_STEP=3 instance for the frame divider.
module tb_box_move_ctrl;

  logic       clk = 1'b0;
  logic       rst_n, stb, kv, bu, bd, bl, br;
  logic [7:0] kc;
  logic [9:0] xl, xr;
  logic [8:0] yt, yb;
  logic       mv_o;
  logic [1:0] dir_o;

  logic       rst2_n, stb2, kv2;
  logic [7:0] kc2;
  logic [9:0] xl2, xr2;
  logic [8:0] yt2, yb2;
  logic       mv2_o;
  logic [1:0] dir2_o;

  int total = 0;
  int bad   = 0;
  int mv    = 0;
  int mv2   = 0;

  always #5 clk = ~clk;

  box_move_ctrl dut (
    .in_clock(clk), .in_reset(rst_n), .in_frame_stb(stb),
    .in_kbd_code(kc), .in_kbd_valid(kv),
    .in_btn_up(bu), .in_btn_down(bd), .in_btn_left(bl), .in_btn_right(br),
    .out_x_left(xl), .out_x_right(xr), .out_y_top(yt), .out_y_bottom(yb),
    .out_move(mv_o), .out_dir(dir_o)
  );

  box_move_ctrl #(.FRAMES_PER_STEP(3)) dut3 (
    .in_clock(clk), .in_reset(rst2_n), .in_frame_stb(stb2),
    .in_kbd_code(kc2), .in_kbd_valid(kv2),
    .in_btn_up(1'b0), .in_btn_down(1'b0), .in_btn_left(1'b0), .in_btn_right(1'b0),
    .out_x_left(xl2), .out_x_right(xr2), .out_y_top(yt2), .out_y_bottom(yb2),
    .out_move(mv2_o), .out_dir(dir2_o)
  );

  function automatic logic [37:0] ed(input int a, input int b, input int c, input int d);
    return {10'(a), 10'(b), 9'(c), 9'(d)};
  endfunction

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk); kc = b; kv = 1'b1;
    @(negedge clk); kv = 1'b0;
  endtask

  task automatic strobe(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk); stb = 1'b1;
      @(negedge clk); stb = 1'b0;
      if (mv_o) mv++;
    end
  endtask

  task automatic send_byte2(input logic [7:0] b);
    @(negedge clk); kc2 = b; kv2 = 1'b1;
    @(negedge clk); kv2 = 1'b0;
  endtask

  task automatic strobe2(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk); stb2 = 1'b1;
      @(negedge clk); stb2 = 1'b0;
      if (mv2_o) mv2++;
    end
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    total++; if ({xl, xr, yt, yb} !== ed(230, 410, 150, 330)) begin bad++; $display("FAIL reset_edges: got %h want %h", {xl, xr, yt, yb}, ed(230, 410, 150, 330)); end
    total++; if ({mv_o, dir_o} !== 3'b000) begin bad++; $display("FAIL reset_move_dir: got %b want 000", {mv_o, dir_o}); end
    rst_n = 1'b1;
  endtask

  task automatic test_idle_strobes;
    mv = 0;
    strobe(5);
    total++; if (mv !== 0) begin bad++; $display("FAIL idle_moves: got %0d want 0", mv); end
    total++; if ({xl, xr, yt, yb} !== ed(230, 410, 150, 330)) begin bad++; $display("FAIL idle_edges: got %h want %h", {xl, xr, yt, yb}, ed(230, 410, 150, 330)); end
  endtask

  task automatic test_key_d;
    send_byte(8'h23);
    mv = 0;
    strobe(4);
    total++; if (mv !== 4) begin bad++; $display("FAIL d_hold_moves: got %0d want 4", mv); end
    total++; if ({xl, xr, yt, yb} !== ed(242, 422, 150, 330)) begin bad++; $display("FAIL d_hold_edges: got %h want %h", {xl, xr, yt, yb}, ed(242, 422, 150, 330)); end
    total++; if (dir_o !== 2'd3) begin bad++; $display("FAIL d_hold_dir: got %0d want 3", dir_o); end
    send_byte(8'hF0); send_byte(8'h23);
    mv = 0;
    strobe(2);
    total++; if (mv !== 0) begin bad++; $display("FAIL d_release_moves: got %0d want 0", mv); end
    total++; if ({xl, xr, yt, yb} !== ed(242, 422, 150, 330)) begin bad++; $display("FAIL d_release_edges: got %h want %h", {xl, xr, yt, yb}, ed(242, 422, 150, 330)); end
  endtask

  task automatic test_wrap_right;
    br = 1'b1;
    strobe(102);
    br = 1'b0;
    total++; if ({xl, xr, yt, yb} !== ed(548, 88, 150, 330)) begin bad++; $display("FAIL cx638_edges: got %h want %h", {xl, xr, yt, yb}, ed(548, 88, 150, 330)); end
    send_byte(8'h23);
    mv = 0;
    strobe(1);
    total++; if ({xl, xr, yt, yb} !== ed(551, 91, 150, 330)) begin bad++; $display("FAIL wrap_right_edges: got %h want %h", {xl, xr, yt, yb}, ed(551, 91, 150, 330)); end
    total++; if (mv !== 1) begin bad++; $display("FAIL wrap_right_moves: got %0d want 1", mv); end
  endtask

  task automatic test_button_wins;
    send_byte(8'hF0); send_byte(8'h23); send_byte(8'h1D);
    bd = 1'b1;
    strobe(1);
    bd = 1'b0;
    total++; if ({xl, xr, yt, yb} !== ed(551, 91, 153, 333)) begin bad++; $display("FAIL btn_down_edges: got %h want %h", {xl, xr, yt, yb}, ed(551, 91, 153, 333)); end
    total++; if (dir_o !== 2'd2) begin bad++; $display("FAIL btn_down_dir: got %0d want 2", dir_o); end
    strobe(1);
    total++; if ({xl, xr, yt, yb} !== ed(551, 91, 150, 330)) begin bad++; $display("FAIL key_w_edges: got %h want %h", {xl, xr, yt, yb}, ed(551, 91, 150, 330)); end
    total++; if (dir_o !== 2'd0) begin bad++; $display("FAIL key_w_dir: got %0d want 0", dir_o); end
  endtask

  task automatic test_priority_ext;
    send_byte(8'h1C);
    strobe(1);
    total++; if ({xl, xr, yt, yb} !== ed(551, 91, 147, 327)) begin bad++; $display("FAIL w_over_a_edges: got %h want %h", {xl, xr, yt, yb}, ed(551, 91, 147, 327)); end
    send_byte(8'hE0); send_byte(8'h1D);
    send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h1C);
    send_byte(8'hF0); send_byte(8'h1D);
    strobe(1);
    total++; if ({xl, xr, yt, yb} !== ed(548, 88, 147, 327)) begin bad++; $display("FAIL wrap_left_edges: got %h want %h", {xl, xr, yt, yb}, ed(548, 88, 147, 327)); end
    total++; if (dir_o !== 2'd1) begin bad++; $display("FAIL wrap_left_dir: got %0d want 1", dir_o); end
    strobe(1);
    total++; if ({xl, xr, yt, yb} !== ed(545, 85, 147, 327)) begin bad++; $display("FAIL left_again_edges: got %h want %h", {xl, xr, yt, yb}, ed(545, 85, 147, 327)); end
    send_byte(8'hF0); send_byte(8'h1C);
    mv = 0;
    strobe(1);
    total++; if (mv !== 0) begin bad++; $display("FAIL no_dir_moves: got %0d want 0", mv); end
    total++; if (dir_o !== 2'd1) begin bad++; $display("FAIL no_dir_hold: got %0d want 1", dir_o); end
  endtask

  task automatic test_same_cycle;
    mv = 0;
    @(negedge clk); kc = 8'h23; kv = 1'b1; stb = 1'b1;
    @(negedge clk); kv = 1'b0; stb = 1'b0;
    if (mv_o) mv++;
    total++; if (mv !== 0) begin bad++; $display("FAIL same_cycle_moves: got %0d want 0", mv); end
    strobe(1);
    total++; if ({xl, xr, yt, yb} !== ed(548, 88, 147, 327)) begin bad++; $display("FAIL same_cycle_later_edges: got %h want %h", {xl, xr, yt, yb}, ed(548, 88, 147, 327)); end
  endtask

  task automatic test_btn_between;
    @(negedge clk); bu = 1'b1;
    @(negedge clk); bu = 1'b0;
    strobe(1);
    total++; if ({xl, xr, yt, yb} !== ed(551, 91, 147, 327)) begin bad++; $display("FAIL btn_between_edges: got %h want %h", {xl, xr, yt, yb}, ed(551, 91, 147, 327)); end
    total++; if (dir_o !== 2'd3) begin bad++; $display("FAIL btn_between_dir: got %0d want 3", dir_o); end
  endtask

  task automatic test_reset_mid;
    send_byte(8'hF0);
    @(negedge clk); #2 rst_n = 1'b0;
    #1;
    total++; if ({xl, xr, yt, yb} !== ed(230, 410, 150, 330)) begin bad++; $display("FAIL async_reset_edges: got %h want %h", {xl, xr, yt, yb}, ed(230, 410, 150, 330)); end
    total++; if (dir_o !== 2'd0) begin bad++; $display("FAIL async_reset_dir: got %0d want 0", dir_o); end
    @(negedge clk); rst_n = 1'b1;
    mv = 0;
    strobe(1);
    total++; if (mv !== 0) begin bad++; $display("FAIL reset_flags_moves: got %0d want 0", mv); end
    send_byte(8'h23);
    strobe(1);
    total++; if (mv !== 1) begin bad++; $display("FAIL post_reset_make_moves: got %0d want 1", mv); end
    total++; if ({xl, xr, yt, yb} !== ed(233, 413, 150, 330)) begin bad++; $display("FAIL post_reset_make_edges: got %h want %h", {xl, xr, yt, yb}, ed(233, 413, 150, 330)); end
  endtask

  task automatic test_divider;
    rst2_n = 1'b1;
    send_byte2(8'h23);
    mv2 = 0;
    strobe2(2);
    total++; if (mv2 !== 0) begin bad++; $display("FAIL div_first_two: got %0d want 0", mv2); end
    strobe2(4);
    total++; if (mv2 !== 2) begin bad++; $display("FAIL div_six_strobes: got %0d want 2", mv2); end
    total++; if ({xl2, xr2, yt2, yb2} !== ed(236, 416, 150, 330)) begin bad++; $display("FAIL div_edges: got %h want %h", {xl2, xr2, yt2, yb2}, ed(236, 416, 150, 330)); end
    strobe2(1);
    @(negedge clk); #2 rst2_n = 1'b0;
    #1;
    total++; if ({xl2, xr2, yt2, yb2} !== ed(230, 410, 150, 330)) begin bad++; $display("FAIL div_reset_edges: got %h want %h", {xl2, xr2, yt2, yb2}, ed(230, 410, 150, 330)); end
    @(negedge clk); rst2_n = 1'b1;
    send_byte2(8'h23);
    mv2 = 0;
    strobe2(2);
    total++; if (mv2 !== 0) begin bad++; $display("FAIL div_after_reset_two: got %0d want 0", mv2); end
    strobe2(1);
    total++; if (mv2 !== 1) begin bad++; $display("FAIL div_after_reset_third: got %0d want 1", mv2); end
    total++; if ({xl2, xr2, yt2, yb2} !== ed(233, 413, 150, 330)) begin bad++; $display("FAIL div_after_reset_edges: got %h want %h", {xl2, xr2, yt2, yb2}, ed(233, 413, 150, 330)); end
  endtask

  initial begin
    rst_n = 1'b0; stb = 1'b0; kv = 1'b0; kc = 8'h00;
    bu = 1'b0; bd = 1'b0; bl = 1'b0; br = 1'b0;
    rst2_n = 1'b0; stb2 = 1'b0; kv2 = 1'b0; kc2 = 8'h00;
    test_reset;
    test_idle_strobes;
    test_key_d;
    test_wrap_right;
    test_button_wins;
    test_priority_ext;
    test_same_cycle;
    test_btn_between;
    test_reset_mid;
    test_divider;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/box_move_ctrl.md
BOX_MOVE_CTRL -- requirements
Module: box_move_ctrl

Interface
REQ-001 Parameter PIX_WIDTH, default 640: horizontal wrap modulus in pixels.
REQ-002 Parameter PIX_HEIGHT, default 480: vertical wrap modulus in pixels.
REQ-003 Parameter PIX_STEP, default 3: pixels moved per step; must be less than both PIX_WIDTH and PIX_HEIGHT.
REQ-004 Parameter BOX_HALF, default 90: half box size in pixels; must be less than both PIX_WIDTH and PIX_HEIGHT.
REQ-005 Parameter FRAMES_PER_STEP, default 1: frame strobes per movement step, range 1..15.
REQ-006 in_clock  input  1  single clock; all state changes on rising edge.
REQ-007 in_reset  input  1  asynchronous, active-low reset.
REQ-008 in_frame_stb  input  1  one-cycle pulse at start of vertical blanking.
REQ-009 in_kbd_code  input  8  PS/2 scan-code byte, qualified by in_kbd_valid.
REQ-010 in_kbd_valid  input  1  one-cycle pulse: in_kbd_code holds a new byte.
REQ-011 in_btn_up, in_btn_down, in_btn_left, in_btn_right  input  1 each  level, already synchronised and debounced.
REQ-012 out_x_left, out_x_right  output  10  box horizontal edges.
REQ-013 out_y_top, out_y_bottom  output  9  box vertical edges.
REQ-014 out_move  output  1  one-cycle pulse when the box position changes.
REQ-015 out_dir  output  2  direction of last move: 0 up, 1 left, 2 down, 3 right.

Function
REQ-016 State: center cx (10 bit, 0..PIX_WIDTH-1) and cy (9 bit, 0..PIX_HEIGHT-1); y=0 is the top of the screen.
REQ-017 Scan-decoder FSM, states IDLE, BREAK, EXT, EXT_BREAK; advances only on in_kbd_valid.
- IDLE: byte 0xF0 -> BREAK; 0xE0 -> EXT; any other byte is a make code -> IDLE.
- BREAK: byte is a break code -> IDLE.
- EXT: 0xF0 -> EXT_BREAK; any other byte is ignored -> IDLE.
- EXT_BREAK: any byte is ignored -> IDLE.
REQ-018 Held-key flags: make of W(0x1D)/A(0x1C)/S(0x1B)/D(0x23) sets the matching flag; a break of the same code clears it; all other codes leave the flags unchanged.
REQ-019 Source arbitration, evaluated on each in_frame_stb:
- if any button is high, the buttons are the source and keyboard flags are ignored;
- otherwise the held-key flags are the source.
REQ-020 Direction priority within the selected source: up/W > left/A > down/S > right/D; exactly one direction is applied per step.
REQ-021 Frame divider: 4-bit counter increments on each in_frame_stb; when it reaches FRAMES_PER_STEP-1 it wraps to 0 and that strobe is a step strobe.
REQ-022 On a step strobe with an active direction, cx/cy update at the same edge; out_move is high for the following cycle only; out_dir is updated.
REQ-023 Step strobe with no direction active: no position change, out_move stays 0, out_dir holds.
REQ-024 Wrap arithmetic:
- right: cx+PIX_STEP >= PIX_WIDTH ? cx+PIX_STEP-PIX_WIDTH : cx+PIX_STEP;
- left: cx < PIX_STEP ? cx+PIX_WIDTH-PIX_STEP : cx-PIX_STEP;
- up and down: same rules on cy with PIX_HEIGHT.
REQ-025 Edges are combinational from cx/cy, each wrapped modulo its axis size:
- out_x_left = cx-BOX_HALF; out_x_right = cx+BOX_HALF;
- out_y_top = cy-BOX_HALF; out_y_bottom = cy+BOX_HALF.
REQ-026 in_kbd_valid and in_frame_stb in the same cycle: the move uses the flags as they were before that edge; the new byte affects only later steps.
REQ-027 Button changes between frame strobes have no effect; only levels sampled at in_frame_stb matter.

Reset
REQ-028 in_reset low immediately (asynchronously) sets:
- cx=PIX_WIDTH/2 and cy=PIX_HEIGHT/2 (edges 230/410 and 150/330 at defaults);
- FSM=IDLE, all flags clear, divider=0, out_move=0, out_dir=0.
REQ-029 Reset asserted mid-sequence (e.g. in BREAK) discards the partial byte sequence; the first byte after release is decoded from IDLE.
REQ-030 After reset is released, the first step occurs on the FRAMES_PER_STEP-th in_frame_stb.

Verification
REQ-031 Reset release, no input, 5 frame strobes -> edges remain 230/410/150/330; out_move never 1.
REQ-032 Bytes 0x23 (D make), 4 strobes, then 0xF0,0x23, 2 strobes -> cx 320->332 with 4 out_move pulses and out_dir=3, then no further movement.
REQ-033 cx=638, D held, 1 strobe -> cx=1; out_x_left=551, out_x_right=91.
REQ-034 in_btn_down high while W is held, 1 strobe -> cy+3 (button wins); release button, 1 strobe -> cy-3.
REQ-035 W and A held -> moves up only; bytes 0xE0,0x1D (extended) -> flags unchanged, FSM returns to IDLE.
REQ-036 FRAMES_PER_STEP=3, D held, 6 strobes -> exactly 2 out_move pulses; in_reset pulsed low mid-sequence -> center restored immediately, divider 0.
